// File: rtl/result_frame_pkg.sv
// result_frame_pkg
//   Shared definitions for the result framer: frame geometry, the default
//   sync byte, the FSM state type, the 80-bit result word type and the
//   helper that picks the byte presented for a given frame index.
package result_frame_pkg;

  localparam int         FRAME_LEN         = 12;  // sync + data + checksum
  localparam int         DATA_BYTES        = 10;
  localparam int         WORD_W            = 8 * DATA_BYTES;
  localparam int         IDX_W             = 4;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // {q_component[39:0], i_component[39:0]}
  typedef logic [WORD_W-1:0] result_word_t;

  // Index 0 is the sync byte, the last index is the checksum, and every
  // data index takes the low byte of the shifter (it is shifted after each
  // data-byte transfer, so the low byte is always the current one).
  function automatic logic [7:0] select_frame_byte(
    input logic [IDX_W-1:0] idx,
    input logic [7:0]       sync,
    input logic [7:0]       data,
    input logic [7:0]       csum
  );
    logic [7:0] sel;
    if (idx == '0) begin
      sel = sync;
    end else if (idx == LAST_IDX) begin
      sel = csum;
    end else begin
      sel = data;
    end
    return sel;
  endfunction

endpackage

// File: rtl/result_word_fifo.sv
// result_word_fifo
//   Small synchronous FIFO of 80-bit result words. Pointers carry one extra
//   MSB so full and empty can be told apart when the address bits match.
//   The head word is readable combinationally so the framer can load it into
//   its shifter on the same edge it pops.
//   Ports:
//     clk_50m, reset : clock, synchronous active-high reset (empties FIFO)
//     push, wr_data  : write strobe/data (caller only pushes when legal)
//     pop, rd_data   : pop strobe / current head word
//     full, empty    : occupancy flags derived from the pointer registers
module result_word_fifo
  import result_frame_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk_50m,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  result_word_t wr_data,
  output result_word_t rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  result_word_t  mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // pointers are.
  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/result_frame_tx.sv
// result_frame_tx
//   Transmit framer for measurement results. Buffers 80-bit result words and
//   sends each as a 12-byte frame: SYNC_BYTE, ten data bytes LSB first, and
//   an 8-bit modular sum of the data bytes, over a valid/ready byte link.
//   Ports:
//     clk_50m, reset        : clock, synchronous active-high reset
//     din_valid, din        : result word write strobe and data
//     full                  : word FIFO holds DEPTH entries
//     byte_out, byte_valid  : frame byte stream (registered)
//     byte_ready            : sink accepts byte_out on this edge
//     busy                  : a frame is in progress (same as byte_valid)
//     frame_count           : completed frames, wraps at 16 bits
//     overflow              : sticky, a word was dropped at a full FIFO
module result_frame_tx
  import result_frame_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic         clk_50m,
  input  logic         reset,
  input  logic         din_valid,
  input  logic [79:0]  din,
  output logic         full,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  input  logic         byte_ready,
  output logic         busy,
  output logic [15:0]  frame_count,
  output logic         overflow
);

  state_t             state_reg,       state_next;
  logic [IDX_W-1:0]   idx_reg,         idx_next;
  result_word_t       shift_reg,       shift_next;
  logic [7:0]         csum_reg,        csum_next;
  logic [15:0]        frame_count_reg, frame_count_next;
  logic               overflow_reg,    overflow_next;
  logic [7:0]         byte_out_reg,    byte_out_next;
  logic               byte_valid_reg,  byte_valid_next;

  logic               pop;
  logic               wr_en;
  logic               fifo_full;
  logic               fifo_empty;
  result_word_t       fifo_rd_data;

  result_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_50m (clk_50m),
    .reset   (reset),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (din),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    shift_next       = shift_reg;
    csum_next        = csum_reg;
    frame_count_next = frame_count_reg;
    pop              = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_rd_data;
          idx_next   = '0;
          csum_next  = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (byte_ready) begin
          if (idx_reg == LAST_IDX) begin
            frame_count_next = frame_count_reg + 16'd1;
            idx_next         = '0;
            // Chain straight into the next frame when a word is waiting so
            // back-to-back frames have no idle cycle between them.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_next = fifo_rd_data;
              csum_next  = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            if (idx_reg != '0) begin
              csum_next  = csum_reg + shift_reg[7:0];
              shift_next = shift_reg >> 8;
            end
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A pop on this edge frees a slot, so a full FIFO can still take a word.
    wr_en         = din_valid && (!fifo_full || pop);
    overflow_next = overflow_reg || (din_valid && !wr_en);

    // Outputs are registered from the next-state values so the byte seen
    // after an edge is exactly the one the FSM moved to on that edge.
    byte_valid_next = (state_next == SEND);
    byte_out_next   = '0;
    if (state_next == SEND) begin
      byte_out_next = select_frame_byte(idx_next, SYNC_BYTE, shift_next[7:0], csum_next);
    end
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      shift_reg       <= '0;
      csum_reg        <= '0;
      frame_count_reg <= '0;
      overflow_reg    <= 1'b0;
      byte_out_reg    <= '0;
      byte_valid_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      shift_reg       <= shift_next;
      csum_reg        <= csum_next;
      frame_count_reg <= frame_count_next;
      overflow_reg    <= overflow_next;
      byte_out_reg    <= byte_out_next;
      byte_valid_reg  <= byte_valid_next;
    end
  end

  assign full        = fifo_full;
  assign byte_out    = byte_out_reg;
  assign byte_valid  = byte_valid_reg;
  assign busy        = byte_valid_reg;
  assign frame_count = frame_count_reg;
  assign overflow    = overflow_reg;

endmodule
